// File: rtl/dmem_lsu_if.sv
// Bundle of pipeline request/response and data-memory port signals for dmem_lsu.
// The slave side is the LSU; the master side is the pipeline plus data memory.
interface dmem_lsu_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W+1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              dmem_wen;
  logic [ADDR_W-1:0] dmem_waddr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ren;
  logic [ADDR_W-1:0] dmem_raddr;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  dmem_wen, dmem_waddr, dmem_wdata, dmem_ren, dmem_raddr,
    output dmem_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output dmem_wen, dmem_waddr, dmem_wdata, dmem_ren, dmem_raddr,
    input  dmem_rdata
  );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit in front of a word-wide data memory with no byte enables.
// Sub-word stores are read-modify-write through a one-cycle MERGE state.
module dmem_lsu #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  dmem_lsu_if.slave   bus
);

  typedef enum logic {IDLE, MERGE} state_t;

  state_t            state_q;
  state_t            state_d;

  logic [ADDR_W-1:0] word_addr;
  logic [1:0]        lane;
  logic              accept;
  logic              misaligned;
  logic              is_word;

  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merge_d;

  logic [DATA_W-1:0] merge_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  assign word_addr = bus.req_addr[ADDR_W+1:2];
  assign lane      = bus.req_addr[1:0];
  assign is_word   = (bus.req_size == 2'b10);

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  always_comb begin
    misaligned = 1'b0;
    case (bus.req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = (lane != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Lane extraction and sign/zero extension of the read word for loads.
  always_comb begin
    ld_byte = 8'h00;
    case (lane)
      2'b00:   ld_byte = bus.dmem_rdata[7:0];
      2'b01:   ld_byte = bus.dmem_rdata[15:8];
      2'b10:   ld_byte = bus.dmem_rdata[23:16];
      default: ld_byte = bus.dmem_rdata[31:24];
    endcase
    ld_half = lane[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];

    load_data = bus.dmem_rdata;
    case (bus.req_size)
      2'b00:   load_data = {{24{bus.req_signed & ld_byte[7]}}, ld_byte};
      2'b01:   load_data = {{16{bus.req_signed & ld_half[15]}}, ld_half};
      default: load_data = bus.dmem_rdata;
    endcase
  end

  // Read word with the addressed byte or half replaced by the store data.
  always_comb begin
    merge_d = bus.dmem_rdata;
    if (bus.req_size == 2'b00) begin
      case (lane)
        2'b00:   merge_d[7:0]   = bus.req_wdata[7:0];
        2'b01:   merge_d[15:8]  = bus.req_wdata[7:0];
        2'b10:   merge_d[23:16] = bus.req_wdata[7:0];
        default: merge_d[31:24] = bus.req_wdata[7:0];
      endcase
    end else if (lane[1]) begin
      merge_d[31:16] = bus.req_wdata[15:0];
    end else begin
      merge_d[15:0] = bus.req_wdata[15:0];
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.dmem_wen   = 1'b0;
    bus.dmem_waddr = '0;
    bus.dmem_wdata = '0;
    bus.dmem_ren   = 1'b0;
    bus.dmem_raddr = '0;

    case (state_q)
      IDLE: begin
        if (accept && !misaligned) begin
          if (bus.req_we && is_word) begin
            bus.dmem_wen   = 1'b1;
            bus.dmem_waddr = word_addr;
            bus.dmem_wdata = bus.req_wdata;
          end else begin
            bus.dmem_ren   = 1'b1;
            bus.dmem_raddr = word_addr;
            if (bus.req_we) state_d = MERGE;
          end
        end
      end
      MERGE: begin
        bus.dmem_wen   = 1'b1;
        bus.dmem_waddr = addr_q;
        bus.dmem_wdata = merge_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset must suppress memory traffic in the same cycle, aborting any merge write.
    if (rst) begin
      bus.dmem_wen = 1'b0;
      bus.dmem_ren = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      merge_q     <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= 1'b0;
      if (state_q == MERGE) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= '0;
        rsp_err_q   <= 1'b0;
      end else if (accept) begin
        if (misaligned) begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b1;
        end else if (!bus.req_we) begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= load_data;
          rsp_err_q   <= 1'b0;
        end else if (is_word) begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
        end else begin
          merge_q <= merge_d;
          addr_q  <= word_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed scenarios then random traffic over a small window of
// words, checked against a byte-level memory model and an in-order response queue.
module tb_dmem_lsu;

  localparam int ADDR_W = 12;
  localparam int NWORDS = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dmem_lsu_if #(.ADDR_W(ADDR_W), .DATA_W(32)) bus ();

  dmem_lsu #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (bus.dmem_wen) mem[bus.dmem_waddr] <= bus.dmem_wdata;
  end

  assign bus.dmem_rdata = mem[bus.dmem_raddr];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;
  bit due_now;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] gmem [0:NWORDS-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Responses arrive in order, each at the cycle the model predicted at accept time.
  always @(negedge clk) begin
    if (mon_en) begin
      due_now = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
      check("rsp_valid", 32'(bus.rsp_valid), 32'(due_now));
      if (due_now) begin
        check("rsp_rdata", bus.rsp_rdata, exp_q[0].rdata);
        check("rsp_err", 32'(bus.rsp_err), 32'(exp_q[0].err));
        void'(exp_q.pop_front());
      end
    end
  end

  // Present one request, wait for acceptance, check the memory-side traffic and
  // record what the response must be. Returns at the negedge after acceptance.
  task automatic do_req(input bit we, input logic [1:0] size, input bit sgn,
                        input logic [13:0] addr, input logic [31:0] wdata);
    int          w;
    int          sh;
    int          waited;
    logic [1:0]  ln;
    bit          err;
    bit          sub;
    logic [31:0] mask;
    logic [31:0] newword;
    logic [31:0] ld;
    w    = int'(addr >> 2);
    ln   = addr[1:0];
    sh   = 8 * int'(ln);
    err  = (size == 2'd3) || ((int'(ln) % (1 << size)) != 0);
    sub  = we && !err && (size != 2'd2);
    mask = (size == 2'd0) ? 32'h0000_00FF : (size == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    newword = 32'h0;

    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;

    waited = 0;
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      check("accept_timeout", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    #1;

    if (err) begin
      check("err_wen", 32'(bus.dmem_wen), 32'd0);
      check("err_ren", 32'(bus.dmem_ren), 32'd0);
      exp_q.push_back('{due: cyc + 1, rdata: 32'd0, err: 1'b1});
    end else if (!we) begin
      check("ld_ren", 32'(bus.dmem_ren), 32'd1);
      check("ld_raddr", 32'(bus.dmem_raddr), 32'(w));
      check("ld_wen", 32'(bus.dmem_wen), 32'd0);
      ld = (gmem[w] >> sh) & mask;
      if (sgn && size != 2'd2 && (ld & ((mask >> 1) + 32'd1)) != 32'd0) ld = ld | ~mask;
      exp_q.push_back('{due: cyc + 1, rdata: ld, err: 1'b0});
    end else begin
      newword = (gmem[w] & ~(mask << sh)) | ((wdata & mask) << sh);
      gmem[w] = newword;
      if (sub) begin
        check("sub_ren", 32'(bus.dmem_ren), 32'd1);
        check("sub_raddr", 32'(bus.dmem_raddr), 32'(w));
        check("sub_wen", 32'(bus.dmem_wen), 32'd0);
        exp_q.push_back('{due: cyc + 2, rdata: 32'd0, err: 1'b0});
      end else begin
        check("st_wen", 32'(bus.dmem_wen), 32'd1);
        check("st_waddr", 32'(bus.dmem_waddr), 32'(w));
        check("st_wdata", bus.dmem_wdata, wdata);
        check("st_ren", 32'(bus.dmem_ren), 32'd0);
        exp_q.push_back('{due: cyc + 1, rdata: 32'd0, err: 1'b0});
      end
    end

    @(negedge clk);
    bus.req_valid = 1'b0;
    if (sub) begin
      check("merge_wen", 32'(bus.dmem_wen), 32'd1);
      check("merge_waddr", 32'(bus.dmem_waddr), 32'(w));
      check("merge_wdata", bus.dmem_wdata, newword);
      check("merge_ready", 32'(bus.req_ready), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [31:0] orig;
  logic [1:0]  r_size;
  logic [1:0]  r_lane;
  int          r_pick;
  int          r_word;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    for (int i = 0; i < NWORDS; i++) gmem[i] = 32'h0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_wen", 32'(bus.dmem_wen), 32'd0);
    check("rst_ren", 32'(bus.dmem_ren), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(bus.req_ready), 32'd1);
    mon_en = 1'b1;

    for (int i = 0; i < NWORDS; i++) do_req(1'b1, 2'd2, 1'b0, 14'(i * 4), $urandom);

    // Word store then word load of the same word.
    do_req(1'b1, 2'd2, 1'b0, 14'h010, 32'hDEAD_BEEF);
    check("tp1_st_valid", 32'(bus.rsp_valid), 32'd1);
    check("tp1_st_rdata", bus.rsp_rdata, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 14'h010, 32'd0);
    check("tp1_ld_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    check("tp1_ld_err", 32'(bus.rsp_err), 32'd0);

    // Byte store read-modify-write.
    do_req(1'b1, 2'd2, 1'b0, 14'h010, 32'h1122_3344);
    do_req(1'b1, 2'd0, 1'b0, 14'h012, 32'h0000_00AB);
    check("tp2_valid_early", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check("tp2_ready_back", 32'(bus.req_ready), 32'd1);
    check("tp2_valid", 32'(bus.rsp_valid), 32'd1);
    check("tp2_mem", mem[4], 32'h11AB_3344);

    // Lane extraction and extension.
    do_req(1'b1, 2'd2, 1'b0, 14'h010, 32'h80F0_7F01);
    do_req(1'b0, 2'd0, 1'b1, 14'h013, 32'd0);
    check("tp3_byte_s", bus.rsp_rdata, 32'hFFFF_FF80);
    do_req(1'b0, 2'd0, 1'b0, 14'h012, 32'd0);
    check("tp3_byte_u", bus.rsp_rdata, 32'h0000_00F0);
    do_req(1'b0, 2'd1, 1'b1, 14'h010, 32'd0);
    check("tp3_half_lo", bus.rsp_rdata, 32'h0000_7F01);
    do_req(1'b0, 2'd1, 1'b1, 14'h012, 32'd0);
    check("tp3_half_hi", bus.rsp_rdata, 32'hFFFF_80F0);

    // Misaligned and illegal accesses.
    do_req(1'b0, 2'd1, 1'b0, 14'h011, 32'd0);
    check("tp4_half_err", 32'(bus.rsp_err), 32'd1);
    check("tp4_half_rdata", bus.rsp_rdata, 32'd0);
    do_req(1'b1, 2'd2, 1'b0, 14'h012, 32'h1234_5678);
    check("tp4_word_err", 32'(bus.rsp_err), 32'd1);
    do_req(1'b0, 2'd3, 1'b0, 14'h010, 32'd0);
    check("tp4_size_err", 32'(bus.rsp_err), 32'd1);
    check("tp4_size_rdata", bus.rsp_rdata, 32'd0);
    check("tp4_mem", mem[4], 32'h80F0_7F01);

    // Load right behind a half store to the same word must see the merged word.
    orig = gmem[5];
    do_req(1'b1, 2'd1, 1'b0, 14'h016, 32'h0000_BEEF);
    do_req(1'b0, 2'd2, 1'b0, 14'h014, 32'd0);
    check("tp5_ld", bus.rsp_rdata, {16'hBEEF, orig[15:0]});

    for (int i = 0; i < 160; i++) begin
      r_pick = int'($urandom_range(0, 9));
      r_size = (r_pick < 3) ? 2'd0 : (r_pick < 6) ? 2'd1 : (r_pick < 9) ? 2'd2 : 2'd3;
      r_word = int'($urandom_range(0, NWORDS - 1));
      r_lane = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) r_lane = 2'd0;
      do_req(1'($urandom_range(0, 1)), r_size, 1'($urandom_range(0, 1)),
             14'(r_word * 4 + int'(r_lane)), $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    repeat (4) @(negedge clk);

    // Reset during MERGE drops the write and the response.
    orig = mem[2];
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 14'h009;
    bus.req_wdata  = 32'h0000_005A;
    #1;
    check("tp6_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("tp6_wen", 32'(bus.dmem_wen), 32'd0);
    check("tp6_rst_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("tp6_ready_after", 32'(bus.req_ready), 32'd1);
    check("tp6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("tp6_mem", mem[2], orig);
    do_req(1'b0, 2'd2, 1'b0, 14'h008, 32'd0);

    repeat (3) @(negedge clk);
    check("rsp_pending", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < NWORDS; i++) check("mem_final", mem[i], gmem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit directly upstream of the data memory. Converts pipeline byte-addressed load/store requests (byte, half, word) into word-addressed accesses on the data memory's single write port and single combinational read port.
- Sub-word stores are done as read-modify-write, because the memory has no byte enables.
- Performs lane extraction and sign/zero extension for loads, and flags misaligned or illegal accesses.

Parameters:
- ADDR_W, 12, data memory word-address width (byte address is ADDR_W+2 bits).
- DATA_W, 32, data word width; fixed at 32 (lane logic assumes 4 byte lanes).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  loads: 1 = sign-extend, 0 = zero-extend; ignored for stores.
- req_addr  in  ADDR_W+2  byte address.
- req_wdata  in  DATA_W  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  single-cycle completion pulse.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned/illegal access; valid with rsp_valid.
- dmem_wen  out  1  memory write enable.
- dmem_waddr  out  ADDR_W  memory write word address.
- dmem_wdata  out  DATA_W  memory write data.
- dmem_ren  out  1  memory read enable.
- dmem_raddr  out  ADDR_W  memory read word address.
- dmem_rdata  in  DATA_W  memory read data, combinational from dmem_raddr.

Behaviour:
- Word address = req_addr[ADDR_W+1:2]; lane = req_addr[1:0].
- Accept = req_valid && req_ready.
- FSM states: IDLE and MERGE. Reset state is IDLE.
- req_ready = 1 in IDLE, 0 in MERGE, 0 while rst=1.
- Error check at accept:
  - size=11 is an error.
  - half with lane[0]=1 is an error.
  - word with lane!=0 is an error.
  - On error: no dmem access; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Load, IDLE, accept:
  - Same cycle: dmem_ren=1, dmem_raddr=word address.
  - Byte: select byte at lane. Half: select lane[1] ? [31:16] : [15:0].
  - Extend per req_signed and register into rsp_rdata.
  - Next cycle rsp_valid=1. Latency 1; back-to-back loads at 1/cycle.
- Word store, IDLE, accept:
  - Same cycle: dmem_wen=1, dmem_waddr=word address, dmem_wdata=req_wdata.
  - Next cycle rsp_valid=1, rsp_rdata=0. Latency 1.
- Sub-word store, IDLE, accept:
  - Same cycle: dmem_ren=1 on the word address.
  - Register into merge_q: dmem_rdata with the target byte/half lane replaced by req_wdata[7:0] / [15:0]. Register word address into addr_q. Go to MERGE.
- MERGE (exactly one cycle):
  - dmem_wen=1, dmem_waddr=addr_q, dmem_wdata=merge_q; req_ready=0.
  - Next cycle: IDLE, rsp_valid=1, rsp_rdata=0, rsp_err=0. Total latency 2.
- dmem_ren is 0 whenever no load or sub-word-store read is issued. dmem_wen is 0 outside word-store accept and MERGE.
- Unused address/data outputs are don't-care; drive 0.
- rsp_valid is a 1-cycle pulse with no backpressure; rsp_rdata/rsp_err hold until the next pulse.
- Ordering: requests complete strictly in order. A load following a sub-word store to the same word cannot be accepted until MERGE has written, so it sees the merged data.
- Reset:
  - rst=1 forces dmem_wen=0 and dmem_ren=0 combinationally.
  - On the next edge: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, merge_q=0, addr_q=0.
  - Reset during MERGE aborts the write: memory is unchanged and no response is issued.

Test Plan:
- Word store addr 0x010, data 0xDEADBEEF; then word load 0x010 -> store: rsp_valid 1 cycle after accept, dmem_waddr=4. Load: rsp_rdata=0xDEADBEEF, rsp_err=0.
- Mem[4]=0x11223344; byte store addr 0x012 data 0xAB -> req_ready low exactly 1 cycle. MERGE writes 0x11AB3344 to word 4. rsp_valid 2 cycles after accept.
- Mem[4]=0x80F0_7F01; loads at addr 0x013 byte signed -> 0xFFFFFF80. Byte unsigned 0x012 -> 0x000000F0. Half signed 0x010 -> 0x00007F01. Half signed 0x012 -> 0xFFFF80F0.
- Half load addr 0x011; word store addr 0x012; size=11 -> each rsp_err=1, rsp_rdata=0, dmem_wen=dmem_ren=0 throughout.
- Half store 0x016 data 0xBEEF, immediately followed by word load 0x014 (req_valid held) -> load accepted after MERGE; returns upper half 0xBEEF with the original lower half.
- rst asserted during MERGE of a byte store -> no dmem write that cycle, memory unchanged, no rsp_valid, req_ready=1 the cycle after rst deasserts.
